// File: rtl/demux16_route_if.sv
// demux16_route_if: handshake bundle for the 1-to-3 result demultiplexer.
//   Upstream side : in_data, in_sel, in_valid -> block; in_ready <- block.
//   Channels A/B/C: out_x_data, out_x_valid <- block; out_x_ready -> block.
//   Debug         : cnt_a, cnt_b, cnt_c accepted-transfer counters.
// modport master is the upstream/consumer side, modport slave is the block.
interface demux16_route_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_sel;
  logic             in_valid;
  logic             in_ready;

  logic [WIDTH-1:0] out_a_data;
  logic             out_a_valid;
  logic             out_a_ready;
  logic [WIDTH-1:0] out_b_data;
  logic             out_b_valid;
  logic             out_b_ready;
  logic [WIDTH-1:0] out_c_data;
  logic             out_c_valid;
  logic             out_c_ready;

  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;
  logic [CNT_W-1:0] cnt_c;

  modport master (
    output in_data, in_sel, in_valid,
    input  in_ready,
    input  out_a_data, out_a_valid,
    output out_a_ready,
    input  out_b_data, out_b_valid,
    output out_b_ready,
    input  out_c_data, out_c_valid,
    output out_c_ready,
    input  cnt_a, cnt_b, cnt_c
  );

  modport slave (
    input  in_data, in_sel, in_valid,
    output in_ready,
    output out_a_data, out_a_valid,
    input  out_a_ready,
    output out_b_data, out_b_valid,
    input  out_b_ready,
    output out_c_data, out_c_valid,
    input  out_c_ready,
    output cnt_a, cnt_b, cnt_c
  );
endinterface

// File: rtl/demux16_route.sv
// demux16_route: registered 1-to-3 demultiplexer for result-bus values.
//   clk : system clock, all state changes on the rising edge
//   rst : synchronous active-high reset (clears data, valids, counters)
//   bus : demux16_route_if.slave
//         in_data/in_sel/in_valid/in_ready  upstream handshake
//         out_{a,b,c}_{data,valid,ready}    one-entry output channels
//         cnt_{a,b,c}                       accepted-transfer counters
// Each channel holds at most one value. in_ready is the only
// combinational output; it looks at the channel selected by in_sel so a
// full channel whose consumer is taking its value this cycle can be
// refilled on the same edge without a bubble.
module demux16_route #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input logic            clk,
  input logic            rst,
  demux16_route_if.slave bus
);
  localparam int NCH = 3;

  logic [WIDTH-1:0] data_r [NCH];
  logic [NCH-1:0]   valid_r;
  logic [CNT_W-1:0] cnt_r  [NCH];

  logic [1:0]       sel_idx_s;
  logic [NCH-1:0]   out_ready_s;
  logic [NCH-1:0]   load_s;
  logic [NCH-1:0]   drain_s;
  logic             in_ready_s;
  logic             accept_s;

  assign out_ready_s = {bus.out_c_ready, bus.out_b_ready, bus.out_a_ready};

  // Channel decode: sel 11 falls into the C arm like the source mux.
  always_comb begin
    sel_idx_s = 2'd2;
    case (bus.in_sel)
      2'b00:   sel_idx_s = 2'd0;
      2'b01:   sel_idx_s = 2'd1;
      2'b10:   sel_idx_s = 2'd2;
      default: sel_idx_s = 2'd2;
    endcase
  end

  // Ready/accept and per-channel load/drain strobes.
  always_comb begin
    in_ready_s = !valid_r[sel_idx_s] || out_ready_s[sel_idx_s];
    accept_s   = bus.in_valid && in_ready_s;
    drain_s    = valid_r & out_ready_s;
    load_s     = {NCH{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      if (accept_s && (sel_idx_s == 2'(i))) begin
        load_s[i] = 1'b1;
      end else begin
        load_s[i] = 1'b0;
      end
    end
  end

  // Channel registers: a load wins over a drain so a simultaneous
  // drain+accept keeps valid high with the new value.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= {NCH{1'b0}};
      for (int i = 0; i < NCH; i++) begin
        data_r[i] <= {WIDTH{1'b0}};
        cnt_r[i]  <= {CNT_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (load_s[i]) begin
          data_r[i]  <= bus.in_data;
          valid_r[i] <= 1'b1;
          cnt_r[i]   <= cnt_r[i] + CNT_W'(1);
        end else if (drain_s[i]) begin
          valid_r[i] <= 1'b0;
        end else begin
          valid_r[i] <= valid_r[i];
        end
      end
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.out_a_data  = data_r[0];
  assign bus.out_a_valid = valid_r[0];
  assign bus.out_b_data  = data_r[1];
  assign bus.out_b_valid = valid_r[1];
  assign bus.out_c_data  = data_r[2];
  assign bus.out_c_valid = valid_r[2];
  assign bus.cnt_a       = cnt_r[0];
  assign bus.cnt_b       = cnt_r[1];
  assign bus.cnt_c       = cnt_r[2];
endmodule
